sprite_move_sched: RTL
======================

SPRITE_MOVE_SCHED -- requirements
Module: sprite_move_sched

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  X_CENTER, 320, X position after reset
  Y_CENTER, 240, Y position after reset
  X_MIN / X_MAX, 0 / 639, screen X bounds
  Y_MIN / Y_MAX, 0 / 479, screen Y bounds
  SIZE, 30, sprite half-extent
  STEP, 5, pixels per move
  REPEAT_DELAY, 15, held frames before auto-repeat starts
  REPEAT_RATE, 3, held frames between auto-repeat steps
REQ-002 Ports SHALL be, as name, direction, width, meaning:
  Clk  in  1  single system clock, all logic on rising edge
  Reset  in  1  synchronous, active-low reset
  frame_tick  in  1  one-Clk-cycle pulse per video frame
  keycode  in  8  current USB keycode
  spriteX  out  10  committed sprite centre X
  spriteY  out  10  committed sprite centre Y
  spriteS  out  10  constant SIZE
  busy  out  1  high when FSM not in IDLE
  moved  out  1  one-cycle pulse when a position changes
  tick_drop  out  1  sticky flag, a frame_tick arrived while busy
REQ-003 Only one clock and one reset SHALL exist: Clk, and Reset (synchronous, active-low).

Function
REQ-004 Direction decode SHALL be: 8'h04 left (-X), 8'h07 right (+X), 8'h16 down (+Y), 8'h1A up (-Y); any other code is "no key".
REQ-005 FSM states SHALL be IDLE, DECODE, STEP, COMMIT; IDLE->DECODE on frame_tick, DECODE->STEP, STEP->COMMIT, COMMIT->IDLE, each unconditional after one cycle.
REQ-006 Latency: spriteX/spriteY and moved SHALL update on the 3rd rising edge after the edge that samples frame_tick; busy is high for exactly 3 cycles per tick.
REQ-007 keycode SHALL be sampled only in DECODE; changes at any other time have no effect.
REQ-008 DECODE, new press (direction key, not equal to prev_key): fire one step; hold counter = 0; phase = DELAY.
REQ-009 DECODE, same direction key held: counter increments by 1. In DELAY, counter == REPEAT_DELAY fires one step, sets counter = 0 and phase = REPEAT. In REPEAT, counter == REPEAT_RATE fires one step and sets counter = 0.
REQ-010 DECODE, no key: no step; counter = 0; phase = DELAY.
REQ-011 prev_key SHALL load keycode in every DECODE; a direct change from one direction key to another counts as a new press.
REQ-012 STEP SHALL compute the candidate position in 11-bit signed arithmetic (no 10-bit wrap) as current position +/- STEP on the fired axis only.
REQ-013 The candidate SHALL be clamped to [X_MIN+SIZE, X_MAX-SIZE] = [30,609] for X and [Y_MIN+SIZE, Y_MAX-SIZE] = [30,449] for Y.
REQ-014 COMMIT SHALL write the clamped candidate. moved pulses high for 1 cycle only if the value differs from the old position; there is no pulse when no step fired or when the clamp holds the position.
REQ-015 A frame_tick while busy SHALL be ignored (no queuing) and SHALL set tick_drop, which stays set until reset.
REQ-016 A frame_tick in the IDLE cycle immediately after COMMIT SHALL be accepted normally.
REQ-017 spriteS SHALL equal SIZE at all times, including reset.

Reset
REQ-018 Reset low at a rising edge SHALL force: state IDLE, spriteX=320, spriteY=240, moved=0, busy=0, tick_drop=0, prev_key=0, counter=0, phase=DELAY.
REQ-019 Reset in any state, including mid DECODE/STEP/COMMIT, SHALL discard the pending move; no moved pulse occurs for it.
REQ-020 Reset SHALL have priority over frame_tick at the same edge.

Verification
REQ-021 Reset, then ticks with keycode 8'h00 -> positions stay (320,240); moved never pulses; busy is high 3 cycles per tick.
REQ-022 Hold 8'h07 from the first tick -> X=325 three cycles after tick 1; no change on held ticks 2-15; X=330 on held tick 16; then +5 every 3rd tick (tick 19 -> 335).
REQ-023 Step X to 605, then press right -> X=609 with moved=1; next fired right step -> X stays 609, moved stays 0.
REQ-024 Holding 8'h07, switch straight to 8'h1A on the next tick -> immediate Y -5 (240->235); repeat timing restarts from REPEAT_DELAY.
REQ-025 frame_tick pulsed during DECODE -> ignored, tick_drop=1, exactly one move occurs; tick_drop stays 1 until Reset low.
REQ-026 Reset driven low during STEP of a right press -> next edge gives (320,240), no moved pulse, busy=0.

Source files
------------

// File: rtl/sprite_move_sched.sv
// Frame-paced sprite mover: decodes a held USB key once per frame,
// steps the sprite with press/auto-repeat timing and clamps to screen.
module sprite_move_sched #(
    parameter int X_CENTER     = 320,
    parameter int Y_CENTER     = 240,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 639,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 479,
    parameter int SIZE         = 30,
    parameter int STEP         = 5,
    parameter int REPEAT_DELAY = 15,
    parameter int REPEAT_RATE  = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    output logic [9:0] spriteX,
    output logic [9:0] spriteY,
    output logic [9:0] spriteS,
    output logic       busy,
    output logic       moved,
    output logic       tick_drop
);

    typedef enum logic [1:0] {IDLE, DECODE, STEP_ST, COMMIT} state_t;

    localparam logic signed [10:0] X_LO = 11'(X_MIN + SIZE);
    localparam logic signed [10:0] X_HI = 11'(X_MAX - SIZE);
    localparam logic signed [10:0] Y_LO = 11'(Y_MIN + SIZE);
    localparam logic signed [10:0] Y_HI = 11'(Y_MAX - SIZE);
    localparam logic signed [10:0] STEP_S = 11'(STEP);

    state_t state, state_nxt;

    logic [7:0] prev_key;
    logic [7:0] hold_cnt;
    logic [7:0] cnt_inc;
    logic       rep_phase;
    logic       fire;
    logic       ax_y;
    logic       neg;
    logic [9:0] cand;

    logic       is_dir;
    logic       is_y;
    logic       is_neg;

    logic signed [10:0] cur;
    logic signed [10:0] sum;
    logic signed [10:0] lo;
    logic signed [10:0] hi;
    logic signed [10:0] clamped;

    assign spriteS = 10'(SIZE);
    assign busy    = (state != IDLE);
    assign cnt_inc = hold_cnt + 8'd1;

    always_comb begin
        is_dir = 1'b1;
        is_y   = 1'b0;
        is_neg = 1'b0;
        unique case (keycode)
            8'h04: is_neg = 1'b1;
            8'h07: ;
            8'h16: is_y = 1'b1;
            8'h1A: begin
                is_y   = 1'b1;
                is_neg = 1'b1;
            end
            default: is_dir = 1'b0;
        endcase
    end

    // Signed 11-bit math so a step below zero clamps instead of wrapping.
    always_comb begin
        cur = ax_y ? 11'(spriteY) : 11'(spriteX);
        sum = neg ? cur - STEP_S : cur + STEP_S;
        lo  = ax_y ? Y_LO : X_LO;
        hi  = ax_y ? Y_HI : X_HI;
        if (sum < lo)
            clamped = lo;
        else if (sum > hi)
            clamped = hi;
        else
            clamped = sum;
    end

    always_ff @(posedge Clk) begin
        if (!Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (frame_tick) state_nxt = DECODE;
            DECODE:  state_nxt = STEP_ST;
            STEP_ST: state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            spriteX   <= 10'(X_CENTER);
            spriteY   <= 10'(Y_CENTER);
            moved     <= 1'b0;
            tick_drop <= 1'b0;
            prev_key  <= 8'h00;
            hold_cnt  <= 8'd0;
            rep_phase <= 1'b0;
            fire      <= 1'b0;
            ax_y      <= 1'b0;
            neg       <= 1'b0;
            cand      <= 10'd0;
        end else begin
            moved <= 1'b0;
            if (frame_tick && state != IDLE)
                tick_drop <= 1'b1;
            unique case (state)
                DECODE: begin
                    prev_key <= keycode;
                    fire     <= 1'b0;
                    ax_y     <= is_y;
                    neg      <= is_neg;
                    if (!is_dir) begin
                        hold_cnt  <= 8'd0;
                        rep_phase <= 1'b0;
                    end else if (keycode != prev_key) begin
                        fire      <= 1'b1;
                        hold_cnt  <= 8'd0;
                        rep_phase <= 1'b0;
                    end else if (!rep_phase && cnt_inc == 8'(REPEAT_DELAY)) begin
                        fire      <= 1'b1;
                        hold_cnt  <= 8'd0;
                        rep_phase <= 1'b1;
                    end else if (rep_phase && cnt_inc == 8'(REPEAT_RATE)) begin
                        fire     <= 1'b1;
                        hold_cnt <= 8'd0;
                    end else begin
                        hold_cnt <= cnt_inc;
                    end
                end
                STEP_ST: cand <= clamped[9:0];
                COMMIT: begin
                    if (fire) begin
                        if (ax_y) begin
                            spriteY <= cand;
                            moved   <= (cand != spriteY);
                        end else begin
                            spriteX <= cand;
                            moved   <= (cand != spriteX);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
